// File: rtl/shift_pkg.sv
// Shared encodings and helpers for the multi-cycle shift/rotate unit.
package shift_pkg;

    localparam logic [2:0] SH_NOP  = 3'b000;
    localparam logic [2:0] SH_LOAD = 3'b001;
    localparam logic [2:0] SH_SLL  = 3'b010;
    localparam logic [2:0] SH_SRL  = 3'b011;
    localparam logic [2:0] SH_SRA  = 3'b100;
    localparam logic [2:0] SH_ROL  = 3'b101;
    localparam logic [2:0] SH_ROR  = 3'b110;
    localparam logic [2:0] SH_RSVD = 3'b111;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_e;

    // Width of the shift-amount port; never below one bit.
    function automatic int unsigned shamt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: applies one shift/rotate op by k (0..STEP) positions.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1,
    parameter int unsigned KW    = $clog2(STEP + 1)
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] value,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] rol_w;
    logic [2*WIDTH-1:0] ror_w;

    always_comb begin
        // Doubled operand turns a rotate into a plain shift plus slice.
        rol_w  = {value, value} << k;
        ror_w  = {value, value} >> k;
        result = value;
        case (op)
            SH_SLL:  result = value << k;
            SH_SRL:  result = value >> k;
            SH_SRA:  result = $signed(value) >>> k;
            SH_ROL:  result = rol_w[2*WIDTH-1:WIDTH];
            SH_ROR:  result = ror_w[WIDTH-1:0];
            default: result = value;
        endcase
    end

endmodule

// File: rtl/shift_reg_unit.sv
// Multi-cycle shift/rotate register with start/busy/done handshake.
// Shifts up to STEP positions per clock until the captured amount is consumed.
module shift_reg_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned STEP    = 1,
    parameter int unsigned SHAMT_W = shamt_width(WIDTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [2:0]         ShiftControl,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] amount,
    output logic [WIDTH-1:0]   data_out,
    output logic               busy,
    output logic               done
);

    localparam int unsigned KW = $clog2(STEP + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] remaining_q, remaining_d;
    logic [2:0]         op_q, op_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [KW-1:0]      k;
    logic [WIDTH-1:0]   step_out;

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .op     (op_q),
        .value  (data_q),
        .k      (k),
        .result (step_out)
    );

    always_comb begin
        if (32'(remaining_q) >= STEP) begin
            k = KW'(STEP);
        end else begin
            k = KW'(remaining_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        remaining_d = remaining_q;
        op_d        = op_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (ShiftControl)
                        SH_LOAD: begin
                            data_d = data_in;
                            done_d = 1'b1;
                        end
                        SH_SLL, SH_SRL, SH_SRA, SH_ROL, SH_ROR: begin
                            data_d = data_in;
                            if (amount == '0) begin
                                done_d = 1'b1;
                            end else begin
                                op_d        = ShiftControl;
                                remaining_d = amount;
                                busy_d      = 1'b1;
                                state_d     = S_SHIFT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_SHIFT: begin
                data_d      = step_out;
                remaining_d = remaining_q - SHAMT_W'(k);
                if (remaining_d == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            remaining_q <= '0;
            op_q        <= SH_NOP;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            remaining_q <= remaining_d;
            op_q        <= op_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign data_out = data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_shift_reg_unit.sv
// Self-checking bench: directed vectors, hand sequences and random ops against a reference model.
module tb_shift_reg_unit;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SLL  = 3'b010;
    localparam logic [2:0] OP_SRL  = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start1 = 1'b0, start4 = 1'b0;
    logic [2:0]  ctl1 = '0, ctl4 = '0;
    logic [31:0] din1 = '0, din4 = '0;
    logic [4:0]  amt1 = '0, amt4 = '0;
    logic [31:0] dout1, dout4;
    logic        busy1, busy4, done1, done4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_reg_unit #(.WIDTH(32), .STEP(1)) u_dut1 (
        .clk (clk), .reset_n (reset_n), .start (start1), .ShiftControl (ctl1),
        .data_in (din1), .amount (amt1), .data_out (dout1), .busy (busy1), .done (done1)
    );

    shift_reg_unit #(.WIDTH(32), .STEP(4)) u_dut4 (
        .clk (clk), .reset_n (reset_n), .start (start4), .ShiftControl (ctl4),
        .data_in (din4), .amount (amt4), .data_out (dout4), .busy (busy4), .done (done4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic s, input logic [2:0] op,
                         input logic [31:0] d, input logic [4:0] a);
        if (sel == 1) begin
            start1 = s; ctl1 = op; din1 = d; amt1 = a;
        end else begin
            start4 = s; ctl4 = op; din4 = d; amt4 = a;
        end
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 1) ? busy1 : busy4;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 1) ? done1 : done4;
    endfunction

    function automatic logic [31:0] get_dout(input int sel);
        return (sel == 1) ? dout1 : dout4;
    endfunction

    // Reference result straight from the op definitions.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x,
                                          input int n);
        logic [31:0] ones = 32'hFFFF_FFFF;
        logic [31:0] r;
        case (op)
            OP_LOAD: r = x;
            OP_SLL:  r = x << n;
            OP_SRL:  r = x >> n;
            OP_SRA:  begin
                r = x >> n;
                if (x[31]) r = r | ~(ones >> n);
            end
            OP_ROL:  r = (n == 0) ? x : ((x << n) | (x >> (32 - n)));
            OP_ROR:  r = (n == 0) ? x : ((x >> n) | (x << (32 - n)));
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] op, input int n, input int step);
        return (op == OP_LOAD || n == 0) ? 0 : (n + step - 1) / step;
    endfunction

    task automatic do_op(input string name, input int sel, input logic [2:0] op,
                         input logic [31:0] d, input logic [4:0] a,
                         input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int early;
        @(negedge clk);
        drive(sel, 1'b1, op, d, a);
        @(posedge clk); #1;
        drive(sel, 1'b0, OP_NOP, 32'h0, 5'd0);
        lat = 0;
        early = 0;
        while (get_busy(sel) && lat < 64) begin
            if (get_done(sel)) early++;
            @(posedge clk); #1;
            lat++;
        end
        check({name, ".data"}, get_dout(sel), exp_res);
        check({name, ".lat"}, 32'(lat), 32'(exp_lat));
        check({name, ".done"}, 32'(get_done(sel)), 32'd1);
        check({name, ".early_done"}, 32'(early), 32'd0);
        @(posedge clk); #1;
        check({name, ".done_clr"}, 32'(get_done(sel)), 32'd0);
    endtask

    typedef struct {
        string       name;
        int          sel;
        logic [2:0]  op;
        logic [31:0] d;
        logic [4:0]  a;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int sel;
        int n;
        logic [2:0] op;
        logic [31:0] d;

        vecs[0] = '{"load",      1, OP_LOAD, 32'h1234_5678, 5'd0,  32'h1234_5678, 0};
        vecs[1] = '{"sra4_s1",   1, OP_SRA,  32'h8000_0000, 5'd4,  32'hF800_0000, 4};
        vecs[2] = '{"srl7_s4",   4, OP_SRL,  32'hF000_0000, 5'd7,  32'h01E0_0000, 2};
        vecs[3] = '{"rol1_s4",   4, OP_ROL,  32'h8000_0001, 5'd1,  32'h0000_0003, 1};
        vecs[4] = '{"ror1_s4",   4, OP_ROR,  32'h0000_0001, 5'd1,  32'h8000_0000, 1};
        vecs[5] = '{"sll0_s1",   1, OP_SLL,  32'h0000_0001, 5'd0,  32'h0000_0001, 0};
        vecs[6] = '{"sll31_s4",  4, OP_SLL,  32'h0000_0001, 5'd31, 32'h8000_0000, 8};
        vecs[7] = '{"ror8_s1",   1, OP_ROR,  32'h1234_5678, 5'd8,  32'h7812_3456, 8};
        vecs[8] = '{"sra_pos",   4, OP_SRA,  32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF, 1};
        vecs[9] = '{"rol4_s4",   4, OP_ROL,  32'h1234_5678, 5'd4,  32'h2345_6781, 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.dout1", dout1, 32'h0);
        check("rst.busy1", 32'(busy1), 32'h0);
        check("rst.done1", 32'(done1), 32'h0);
        check("rst.dout4", dout4, 32'h0);
        check("rst.busy4", 32'(busy4), 32'h0);
        check("rst.done4", 32'(done4), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].name, vecs[i].sel, vecs[i].op, vecs[i].d, vecs[i].a,
                  vecs[i].exp, vecs[i].lat);
        end

        // Reserved and nop ops leave the register alone
        do_op("preload", 1, OP_LOAD, 32'hCAFE_BABE, 5'd0, 32'hCAFE_BABE, 0);
        @(negedge clk);
        drive(1, 1'b1, OP_RSVD, 32'h1111_1111, 5'd3);
        @(posedge clk); #1;
        drive(1, 1'b1, OP_NOP, 32'h2222_2222, 5'd3);
        check("rsvd.done", 32'(done1), 32'h0);
        check("rsvd.busy", 32'(busy1), 32'h0);
        check("rsvd.data", dout1, 32'hCAFE_BABE);
        @(posedge clk); #1;
        drive(1, 1'b0, OP_NOP, 32'h0, 5'd0);
        check("nop.done", 32'(done1), 32'h0);
        check("nop.data", dout1, 32'hCAFE_BABE);

        // Start while busy is ignored
        @(negedge clk);
        drive(1, 1'b1, OP_SLL, 32'h0000_0001, 5'd10);
        @(posedge clk); #1;
        drive(1, 1'b0, OP_NOP, 32'h0, 5'd0);
        lat = 0;
        while (busy1 && lat < 64) begin
            if (lat == 2) drive(1, 1'b1, OP_LOAD, 32'hFFFF_FFFF, 5'd0);
            @(posedge clk); #1;
            if (lat == 2) drive(1, 1'b0, OP_NOP, 32'h0, 5'd0);
            lat++;
        end
        check("ignore.lat", 32'(lat), 32'd10);
        check("ignore.data", dout1, 32'h0000_0400);
        check("ignore.done", 32'(done1), 32'h1);

        // Back-to-back: new start accepted while done is high
        do_op("b2b_pre", 4, OP_LOAD, 32'h0, 5'd0, 32'h0, 0);
        @(negedge clk);
        drive(4, 1'b1, OP_SLL, 32'h0000_0001, 5'd4);
        @(posedge clk); #1;
        drive(4, 1'b0, OP_NOP, 32'h0, 5'd0);
        @(posedge clk); #1;
        check("b2b.first_done", 32'(done4), 32'h1);
        check("b2b.first_data", dout4, 32'h0000_0010);
        @(negedge clk);
        drive(4, 1'b1, OP_ROR, 32'h0000_0001, 5'd1);
        @(posedge clk); #1;
        drive(4, 1'b0, OP_NOP, 32'h0, 5'd0);
        check("b2b.accept_busy", 32'(busy4), 32'h1);
        check("b2b.accept_done", 32'(done4), 32'h0);
        @(posedge clk); #1;
        check("b2b.second_done", 32'(done4), 32'h1);
        check("b2b.second_data", dout4, 32'h8000_0000);

        // Asynchronous reset mid-operation
        @(negedge clk);
        drive(1, 1'b1, OP_SRL, 32'hFFFF_FFFF, 5'd20);
        @(posedge clk); #1;
        drive(1, 1'b0, OP_NOP, 32'h0, 5'd0);
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst.data", dout1, 32'h0);
        check("arst.busy", 32'(busy1), 32'h0);
        check("arst.done", 32'(done1), 32'h0);
        @(posedge clk); #1;
        check("arst.hold_done", 32'(done1), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("arst.after_done", 32'(done1), 32'h0);
        do_op("post_rst_load", 1, OP_LOAD, 32'hA5A5_A5A5, 5'd0, 32'hA5A5_A5A5, 0);

        // Random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            sel = ($urandom_range(0, 1) == 0) ? 1 : 4;
            op  = 3'($urandom_range(1, 6));
            d   = $urandom;
            n   = $urandom_range(0, 31);
            do_op($sformatf("rnd%0d", i), sel, op, d, 5'(n), model(op, d, n),
                  model_lat(op, n, sel));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_reg_unit.md
Name: shift_reg_unit

Overview:
Parametrised, multi-cycle shift/rotate register for the datapath.
- Loads a WIDTH-bit operand and applies shift or rotate operations using the existing 3-bit ShiftControl encoding, extended with rotates.
- Shifts by up to STEP bit positions per clock, with a start/busy/done handshake.
- Sits between the register file/ALU-source muxes and the write-back mux; the control FSM starts it and waits on done.

Parameters:
WIDTH, 32, operand/result width in bits (>=2).
STEP, 1, maximum bit positions shifted per clock; power of two, 1..WIDTH.
SHAMT_W, $clog2(WIDTH), width of the amount port; derived, do not override.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request; sampled only in IDLE.
ShiftControl  input  3  op: 000 nop, 001 load, 010 sll, 011 srl, 100 sra, 101 rol, 110 ror, 111 reserved.
data_in  input  WIDTH  source operand, captured on accepted start.
amount  input  SHAMT_W  shift distance, captured on accepted start (0..WIDTH-1).
data_out  output  WIDTH  working register; valid whenever busy=0.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse marking completion.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, data_out=0, busy=0, done=0, remaining count=0. Reset mid-operation aborts immediately with no done pulse.
- States: IDLE, SHIFT.
- IDLE:
  - start=1 with op 001 (load): data_out<=data_in; done=1 on that edge; stay IDLE; busy stays 0.
  - start=1 with op 010..110 and amount=0: data_out<=data_in; done=1 on that edge; stay IDLE.
  - start=1 with op 010..110 and amount>0: data_out<=data_in; latch op; remaining<=amount; busy<=1; go to SHIFT.
  - start=0, or op 000/111: no state change, no done.
- SHIFT, each edge:
  - k = min(STEP, remaining).
  - data_out <= step(op, data_out, k); remaining <= remaining-k.
  - When remaining-k == 0: busy<=0, done<=1, go to IDLE.
- Total shift latency: ceil(amount/STEP) clocks after the start edge. done is high for exactly the cycle following the final step edge.
- done is a registered pulse cleared on the next edge unless a new completion occurs. Back-to-back: start may be accepted in the same cycle done is high, since the unit is already IDLE.
- start while busy=1 is ignored; captured op, amount and data are unaffected.
- Inputs data_in, ShiftControl and amount are don't-care outside accepted start cycles.
- Arithmetic:
  - sll/srl fill with 0.
  - sra replicates the MSB of the current working value.
  - rol/ror wrap bits end-around.
  - All results truncated to WIDTH; k never exceeds WIDTH-1.
- data_out shows intermediate values during SHIFT; consumers read only when busy=0.

Decomposition:
- Package shift_pkg: localparams for the ShiftControl encodings (SH_NOP, SH_LOAD, SH_SLL, SH_SRL, SH_SRA, SH_ROL, SH_ROR), the state enum (S_IDLE, S_SHIFT), and a helper for SHAMT_W.
- Sub-module shift_step: purely combinational (op, value, k) -> shifted value, parametrised by WIDTH and STEP. It implements the five shift/rotate ops for k in 0..STEP; instantiated once.
- shift_reg_unit holds the FSM, remaining counter, working register and handshake.

Test Plan:
1. WIDTH=32, STEP=1: load 0x12345678 -> data_out=0x12345678 on next edge, done pulse 1 cycle, busy never high.
2. STEP=1: sra 0x80000000 by 4 -> busy for 4 clocks, then data_out=0xF8000000 and single done pulse.
3. STEP=4: srl 0xF0000000 by 7 -> 2 shift clocks (4 then 3), data_out=0x01E00000. Also rol 0x80000001 by 1 -> 0x00000003, and ror 0x00000001 by 1 -> 0x80000000.
4. sll 0x00000001 by 0 -> done on next edge, data_out=0x00000001, busy stays 0. Pulse start with op 111 -> no done, data_out unchanged.
5. STEP=1: start sll 0x1 by 10; at clock 3 assert start with load 0xFFFFFFFF -> ignored, final data_out=0x00000400.
6. STEP=1: start srl by 20; drop reset_n mid-operation, asynchronous to clk -> data_out=0, busy=0 immediately, no done. After release, a new load 0xA5A5A5A5 completes normally.
